// File: rtl/mem_arbiter.sv
`timescale 1ns/1ps
// Two-requester arbiter sharing one synchronous memory port between the core and the
// loader/DMA port; accesses are serialised with round-robin tie-breaking.
module mem_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MEM_LAT = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          core_req,
    input  logic          core_we,
    input  logic [AW-1:0] core_adr,
    input  logic [DW-1:0] core_wd,
    output logic          core_ack,
    output logic [DW-1:0] core_rd,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_adr,
    input  logic [DW-1:0] dma_wd,
    output logic          dma_ack,
    output logic [DW-1:0] dma_rd,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_adr,
    output logic [DW-1:0] mem_wd,
    input  logic [DW-1:0] mem_rd,
    output logic          busy
);

    localparam int            CW       = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(MEM_LAT - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, ACK} state_t;

    state_t        state;
    logic          owner;
    logic          last;
    logic [CW-1:0] cnt;
    logic [DW-1:0] rdata;
    logic [DW-1:0] core_rd_q;
    logic [DW-1:0] dma_rd_q;
    logic          pick_dma;

    // owner/last: 1 = dma, 0 = core. On a tie the requester not served last wins.
    assign pick_dma = dma_req && (!core_req || !last);

    // During the ack cycle the owner sees the freshly captured word; otherwise each
    // port keeps showing the last word it was handed.
    assign core_rd = core_ack ? rdata : core_rd_q;
    assign dma_rd  = dma_ack  ? rdata : dma_rd_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            owner     <= 1'b0;
            last      <= 1'b1;
            cnt       <= '0;
            rdata     <= '0;
            core_rd_q <= '0;
            dma_rd_q  <= '0;
            core_ack  <= 1'b0;
            dma_ack   <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_adr   <= '0;
            mem_wd    <= '0;
            busy      <= 1'b0;
        end else begin
            core_ack <= 1'b0;
            dma_ack  <= 1'b0;
            mem_en   <= 1'b0;
            mem_we   <= 1'b0;
            case (state)
                IDLE: begin
                    if (core_req || dma_req) begin
                        owner   <= pick_dma;
                        last    <= pick_dma;
                        mem_en  <= 1'b1;
                        mem_we  <= pick_dma ? dma_we  : core_we;
                        mem_adr <= pick_dma ? dma_adr : core_adr;
                        mem_wd  <= pick_dma ? dma_wd  : core_wd;
                        cnt     <= CNT_LOAD;
                        busy    <= 1'b1;
                        state   <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (cnt == '0) begin
                        state <= CAPTURE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                CAPTURE: begin
                    // Writes capture too, so every access has the same ack latency.
                    rdata    <= mem_rd;
                    core_ack <= !owner;
                    dma_ack  <= owner;
                    state    <= ACK;
                end
                ACK: begin
                    if (owner) begin
                        dma_rd_q <= rdata;
                    end else begin
                        core_rd_q <= rdata;
                    end
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
